// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction fetch initiator. Holds the fetch PC, issues one
//               word request per cycle to instruction memory while buffer
//               credit remains, and queues returned words with their PCs in
//               a small FIFO for decode. A redirect flushes the buffer, drops
//               any in-flight response and restarts fetch at the new PC.
//               Optional performance counters: define IFETCH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    // Occupancy (count + inflight) needs one bit more than count.
    localparam logic [c_CNT_W:0] c_DEPTH_OCC = (c_CNT_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [31:0]         r_fetch_pc;
    logic                r_inflight;
    logic [31:0]         r_inflight_pc;

    logic [31:0]         r_fifo_instr [FIFO_DEPTH];
    logic [31:0]         r_fifo_pc    [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [1:0]          w_state_nxt;
    logic                w_redirect;
    logic                w_credit;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic [c_CNT_W-1:0]  w_count_nxt;
    logic [c_CNT_W:0]    w_occ;
    logic [c_CNT_W:0]    w_occ_nxt;
    logic [31:0]         w_redirect_target;
    logic                w_unused_pc_lsbs;

    // Redirect target is word aligned; the low address bits carry no meaning.
    assign w_redirect_target = {redirect_pc[31:2], 2'b00};
    assign w_unused_pc_lsbs  = &{1'b0, redirect_pc[1:0]};

    // A redirect seen before the first fetch cycle has nothing to restart.
    assign w_redirect = redirect_valid && (r_state != c_ST_IDLE);

    // Credit uses registered occupancy only: a same-cycle pop does not free
    // a slot until the following cycle, which keeps this path short.
    assign w_occ    = {1'b0, r_count} + (c_CNT_W + 1)'(r_inflight);
    assign w_credit = (w_occ < c_DEPTH_OCC);
    assign w_issue  = (r_state == c_ST_FETCH) && w_credit;

    // The word returned this cycle belongs to the previous request, unless a
    // redirect makes it stale.
    assign w_push = r_inflight && !w_redirect;

    // Head is hidden during a redirect cycle, so no pop can happen then.
    assign out_valid = (r_count != '0) && !redirect_valid;
    assign w_pop     = out_valid && out_ready;

    assign w_count_nxt = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    assign w_occ_nxt   = {1'b0, w_count_nxt} + (c_CNT_W + 1)'(w_issue);

    // ------------------------------------------------------------------------
    // Memory-side outputs
    // ------------------------------------------------------------------------
    assign imem_req  = w_issue;
    assign imem_addr = r_fetch_pc;

    // ------------------------------------------------------------------------
    // Decode-side outputs: head of the buffer
    // ------------------------------------------------------------------------
    assign out_instr = r_fifo_instr[r_rd_ptr];
    assign out_pc    = r_fifo_pc[r_rd_ptr];

    // Next fetch state: decided from occupancy after this edge's updates.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                w_state_nxt = c_ST_FETCH;
            end
            c_ST_FETCH, c_ST_FULL: begin
                if (w_redirect) begin
                    w_state_nxt = c_ST_FETCH;
                end else if (w_occ_nxt >= c_DEPTH_OCC) begin
                    w_state_nxt = c_ST_FULL;
                end else begin
                    w_state_nxt = c_ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Fetch state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch PC: redirect wins over sequential advance; wraps at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_fetch_pc <= w_redirect_target;
        end else if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    // In-flight tracking: one outstanding request, replaced back-to-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'd0;
        end else if (w_redirect) begin
            r_inflight    <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
            end
        end
    end

    // Buffer storage: capture the returned word with the PC that fetched it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_instr[i] <= 32'd0;
                r_fifo_pc[i]    <= 32'd0;
            end
        end else if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

    // Buffer pointers and occupancy; a redirect empties the buffer outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

`ifdef IFETCH_PERF_EN
    // A flush counts only when the redirect actually throws work away:
    // buffered entries, the response arriving now, or the request issued now.
    logic w_flush_loss;
    assign w_flush_loss = w_redirect && ((r_count != '0) || r_inflight || w_issue);

    // Performance counters: accepted instructions and lossy redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (w_pop) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (w_flush_loss) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Directed self-checking bench for ifetch_unit. A memory model
//               answers requests one cycle later; a scoreboard queue receives
//               the expected PC at each request and is drained as decode
//               accepts entries. Redirects and resets clear the scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] exp_fetch = RESET_PC;
    int n_issue   = 0;
    int n_pop     = 0;
    int cyc       = 0;
    int first_req = -1;
    int first_val = -1;
    int pop3_cyc  = -1;
    int idx;

    ifetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory contents: a few real instructions, then a pattern.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        case (a)
            32'h0000_0000: word_of = 32'h0080_0513;
            32'h0000_0004: word_of = 32'h0095_0593;
            32'h0000_0008: word_of = 32'h40a5_8633;
            default:       word_of = {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    // Memory: data for a request sampled at edge k is valid the next cycle.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? word_of(imem_addr) : 32'hBAD0_BAD0;
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_true(input string tag, input bit cond);
        total++;
        assert (cond) else begin
            bad++;
            $error("FAIL %s: observed=0 expected=1", tag);
        end
    endtask

    // Scoreboard monitor, sampled at the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pop_log.delete();
            exp_fetch = RESET_PC;
            n_issue   = 0;
            n_pop     = 0;
            first_req = -1;
            first_val = -1;
            pop3_cyc  = -1;
        end else if (redirect_valid) begin
            check32("redir_valid_mask", {31'd0, out_valid}, 32'd0);
            exp_q.delete();
            exp_fetch = {redirect_pc[31:2], 2'b00};
        end else begin
            if (out_valid && first_val < 0) first_val = cyc;
            if (out_valid && out_ready) begin
                check_true("pop_expected", exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check32("out_pc", out_pc, e);
                    check32("out_instr", out_instr, word_of(e));
                end
                pop_log.push_back(out_pc);
                n_pop++;
                if (n_pop == 3 && pop3_cyc < 0) pop3_cyc = cyc;
            end
            if (imem_req) begin
                if (first_req < 0) first_req = cyc;
                check32("issue_addr", imem_addr, exp_fetch);
                exp_q.push_back(exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
                n_issue++;
            end
        end
    end

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // ---- reset values
        check32("rst_imem_req",  {31'd0, imem_req},  32'd0);
        check32("rst_imem_addr", imem_addr,          RESET_PC);
        check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check32("rst_out_instr", out_instr,          32'd0);
        check32("rst_out_pc",    out_pc,             32'd0);

        // ---- streaming fetch with decode always ready
        out_ready = 1'b1;
        rst       = 1'b0;
        for (int g = 0; g < 60 && pop3_cyc < 0; g++) @(posedge clk);
        #1;
        check_true("t1_timeout", pop3_cyc >= 0);
        check32("t1_latency",   32'(first_val - first_req), 32'd2);
        check32("t1_one_per_cycle", 32'(pop3_cyc - first_val), 32'd2);
        check32("t1_pc0", pop_log[0], 32'h0);
        check32("t1_pc1", pop_log[1], 32'h4);
        check32("t1_pc2", pop_log[2], 32'h8);

        // ---- decode stalled: buffer fills, fetch stops at 16
        @(posedge clk); #1;
        rst       = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check32("t2_full_req",   {31'd0, imem_req},  32'd0);
        check32("t2_full_addr",  imem_addr,          32'd16);
        check32("t2_issues",     32'(n_issue),       32'd4);
        check32("t2_full_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        for (int g = 0; g < 60 && n_pop < 6; g++) @(posedge clk);
        #1;
        check_true("t2_timeout", n_pop >= 6);
        for (int i = 0; i < 6 && i < pop_log.size(); i++) begin
            check32($sformatf("t2_pop%0d", i), pop_log[i], 32'(4 * i));
        end

        // ---- redirect with 3 buffered entries and one request in flight
        @(posedge clk); #1;
        rst       = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int g = 0; g < 40 && n_issue < 4; g++) @(posedge clk);
        #1;
        check_true("t3_timeout", n_issue >= 4);
        check32("t3_pre_valid", {31'd0, out_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0020;
        out_ready      = 1'b1;
        #1;
        check32("t3_mask", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        check32("t3_req_r1",   {31'd0, imem_req},  32'd1);
        check32("t3_addr_r1",  imem_addr,          32'h20);
        check32("t3_valid_r1", {31'd0, out_valid}, 32'd0);
`ifdef IFETCH_PERF_EN
        check32("t3_perf_flush", perf_flush_cnt, 32'd1);
`endif
        @(posedge clk); #1;
        check32("t3_valid_r2", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check32("t3_valid_r3", {31'd0, out_valid}, 32'd1);
        check32("t3_pc_r3",    out_pc,             32'h20);

        // ---- misaligned redirect target
        repeat (3) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0033;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        idx = pop_log.size();
        check32("t4_addr", imem_addr, 32'h30);
        for (int g = 0; g < 20 && pop_log.size() <= idx; g++) @(posedge clk);
        #1;
        check_true("t4_timeout", pop_log.size() > idx);
        if (pop_log.size() > idx) check32("t4_pc", pop_log[idx], 32'h30);

        // ---- PC wrap through the top of the address space
        repeat (2) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        idx = pop_log.size();
        for (int g = 0; g < 20 && pop_log.size() < idx + 3; g++) @(posedge clk);
        #1;
        check_true("t5_timeout", pop_log.size() >= idx + 3);
        if (pop_log.size() >= idx + 3) begin
            check32("t5_pc0", pop_log[idx],     32'hFFFF_FFF8);
            check32("t5_pc1", pop_log[idx + 1], 32'hFFFF_FFFC);
            check32("t5_pc2", pop_log[idx + 2], 32'h0000_0000);
        end

        // ---- asynchronous reset between edges mid-stream
        repeat (3) @(posedge clk);
        #1;
`ifdef IFETCH_PERF_EN
        check32("t6_perf_fetch", perf_fetch_cnt, 32'(n_pop));
`endif
        #2;
        rst = 1'b1;
        #1;
        check32("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check32("t6_rst_req",   {31'd0, imem_req},  32'd0);
        check32("t6_rst_addr",  imem_addr,          RESET_PC);
`ifdef IFETCH_PERF_EN
        check32("t6_rst_perf_fetch", perf_fetch_cnt, 32'd0);
        check32("t6_rst_perf_flush", perf_flush_cnt, 32'd0);
`endif
        #3;
        rst = 1'b0;
        for (int g = 0; g < 30 && pop_log.size() < 2; g++) @(posedge clk);
        #1;
        check_true("t6_timeout", pop_log.size() >= 2);
        if (pop_log.size() >= 2) begin
            check32("t6_pc0", pop_log[0], RESET_PC);
            check32("t6_pc1", pop_log[1], RESET_PC + 32'd4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
